// File: rtl/score_pkg.sv
// Shared defaults and FSM encoding for the score history reader.
package score_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DIGITS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAPTURE,
    CONVERT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter: one shift-add-3 step per cycle, DATA_W steps per conversion.
module bcd_double_dabble #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   din,
  output logic [4*DIGITS-1:0] dout,
  output logic                ready
);

  localparam int SR_W  = 4*DIGITS + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [SR_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_count;
  logic             r_run;

  logic [SR_W-1:0]  w_adj;
  logic [SR_W-1:0]  w_next;

  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shift[DATA_W + 4*d +: 4] >= 4'd5) begin
        w_adj[DATA_W + 4*d +: 4] = r_shift[DATA_W + 4*d +: 4] + 4'd3;
      end
    end
    w_next = w_adj << 1;
  end

  // ready flags the final step, so dout is the finished value in that same cycle
  assign ready = r_run && (r_count == CNT_W'(DATA_W - 1));
  assign dout  = w_next[SR_W-1 -: 4*DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (abort) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (start) begin
      r_shift <= {{(4*DIGITS){1'b0}}, din};
      r_count <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_shift <= w_next;
      if (ready) begin
        r_count <= '0;
        r_run   <= 1'b0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_history_reader.sv
// Browses the score memory with a cursor and converts the selected entry to BCD.
// Define SCORE_HISTORY_WRAP_EN for a wrapping cursor; otherwise the cursor saturates.
module score_history_reader
  import score_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                viewScore,
  input  logic                nextKey,
  input  logic                prevKey,
  input  logic [ADDR_W-1:0]   writeAddress,
  input  logic                writeEnS,
  input  logic [DATA_W-1:0]   readScore,
  output logic [ADDR_W-1:0]   rdAddress,
  output logic [4*DIGITS-1:0] digits,
  output logic                valid,
  output logic                done,
  output logic                busy,
  output logic                isLatest
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cursor;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_valid;
  logic                r_done;
  logic                r_busy;
  logic                r_viewQ;
  logic                r_armed;

  logic                w_entry;
  logic                w_keyValid;
  logic                w_atEdge;
  logic                w_stepOk;
  logic [ADDR_W-1:0]   w_stepAddr;
  logic                w_convStart;
  logic                w_convAbort;
  logic                w_convReady;
  logic [4*DIGITS-1:0] w_convDout;

  // r_armed blocks a spurious entry when viewScore is already high as reset releases
  assign w_entry    = viewScore && !r_viewQ && r_armed;
  assign w_keyValid = viewScore && (r_state == IDLE || r_state == DONE) && (nextKey != prevKey);
  assign w_stepAddr = nextKey ? (r_cursor - ADDR_W'(1)) : (r_cursor + ADDR_W'(1));

`ifdef SCORE_HISTORY_WRAP_EN
  assign w_atEdge = 1'b0;
`else
  localparam logic [ADDR_W-1:0] CURSOR_MAX = '1;
  assign w_atEdge = nextKey ? (r_cursor == '0) : (r_cursor == CURSOR_MAX);
`endif

  assign w_stepOk    = w_keyValid && !w_atEdge;
  assign w_convStart = (r_state == CAPTURE) && viewScore && !writeEnS;
  assign w_convAbort = !viewScore;

  bcd_double_dabble #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (Clock),
    .rst_n (reset),
    .start (w_convStart),
    .abort (w_convAbort),
    .din   (readScore),
    .dout  (w_convDout),
    .ready (w_convReady)
  );

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cursor <= '0;
      r_digits <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_viewQ  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_viewQ <= viewScore;
      r_done  <= 1'b0;
      if (!viewScore) begin
        r_armed <= 1'b1;
      end
      if (!viewScore) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_entry) begin
        r_cursor <= writeAddress;
        r_valid  <= 1'b0;
        r_busy   <= 1'b1;
        r_state  <= WAIT;
      end else begin
        // a writer cycle on the shared port in WAIT/CAPTURE spoils the read, so refetch
        case (r_state)
          IDLE, DONE: begin
            if (w_stepOk) begin
              r_cursor <= w_stepAddr;
              r_valid  <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= WAIT;
            end
          end
          WAIT: begin
            if (!writeEnS) begin
              r_state <= CAPTURE;
            end
          end
          CAPTURE: begin
            r_state <= writeEnS ? WAIT : CONVERT;
          end
          CONVERT: begin
            if (w_convReady) begin
              r_digits <= w_convDout;
              r_valid  <= 1'b1;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rdAddress = r_cursor;
  assign digits    = r_digits;
  assign valid     = r_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign isLatest  = (r_cursor == writeAddress);

endmodule

// File: tb/tb_score_history_reader.sv
// Bench for score_history_reader: random browsing checked against a decimal reference model.
// Follows SCORE_HISTORY_WRAP_EN the same way as the design build.
module tb_score_history_reader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DIGITS = 10;
  localparam int SLOTS  = 1 << ADDR_W;

  logic                Clock;
  logic                reset;
  logic                viewScore;
  logic                nextKey;
  logic                prevKey;
  logic [ADDR_W-1:0]   writeAddress;
  logic                writeEnS;
  logic [DATA_W-1:0]   readScore;
  logic [ADDR_W-1:0]   rdAddress;
  logic [4*DIGITS-1:0] digits;
  logic                valid;
  logic                done;
  logic                busy;
  logic                isLatest;

  logic [DATA_W-1:0]   mem [SLOTS];
  int                  checks = 0;
  int                  errors = 0;
  int                  expCursor;
  logic [4*DIGITS-1:0] expDigits;

  score_history_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) dut (
    .Clock        (Clock),
    .reset        (reset),
    .viewScore    (viewScore),
    .nextKey      (nextKey),
    .prevKey      (prevKey),
    .writeAddress (writeAddress),
    .writeEnS     (writeEnS),
    .readScore    (readScore),
    .rdAddress    (rdAddress),
    .digits       (digits),
    .valid        (valid),
    .done         (done),
    .busy         (busy),
    .isLatest     (isLatest)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous-read memory: data appears one cycle after the address is registered
  always @(posedge Clock) readScore <= mem[rdAddress];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Decimal digits by repeated division
  function automatic logic [4*DIGITS-1:0] refBcd(input logic [DATA_W-1:0] value);
    logic [4*DIGITS-1:0] result;
    longint unsigned     rest;
    result = '0;
    rest   = 64'(value);
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return result;
  endfunction

  function automatic int stepCursor(input int c, input int dir);
`ifdef SCORE_HISTORY_WRAP_EN
    return (c + dir + SLOTS) % SLOTS;
`else
    if (c + dir < 0 || c + dir > SLOTS - 1) return c;
    return c + dir;
`endif
  endfunction

  // A fetch needs two consecutive quiet cycles on the shared port (address, then data);
  // conversion and the done cycle follow in DATA_W + 1 more cycles.
  function automatic int expLatency(input logic [7:0] wePat);
    int lowRun;
    lowRun = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 8 && wePat[c-1]) lowRun = 0;
      else lowRun++;
      if (lowRun == 2) return c + DATA_W + 1;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input logic nk, input logic pk);
    nextKey = nk;
    prevKey = pk;
    tick();
    nextKey = 1'b0;
    prevKey = 1'b0;
  endtask

  task automatic leave();
    viewScore = 1'b0;
    tick();
    checkOutput("leave.valid", 64'(valid), 64'(0));
    checkOutput("leave.busy", 64'(busy), 64'(0));
  endtask

  task automatic enter(input int addr);
    writeAddress = ADDR_W'(addr);
    viewScore    = 1'b1;
    tick();
    expCursor = addr;
  endtask

  // Called right after the trigger edge; drives writeEnS per cycle and waits for done.
  task automatic runFetch(input string tag, input logic [7:0] wePat, input logic pokeKey);
    int target;
    int lat;
    logic earlyValid;
    target     = expLatency(wePat);
    lat        = 1;
    earlyValid = 1'b0;
    checkOutput({tag, ".busy"}, 64'(busy), 64'(1));
    checkOutput({tag, ".addr"}, 64'(rdAddress), 64'(expCursor));
    while (!done && lat < target + 8) begin
      if (valid) earlyValid = 1'b1;
      if (lat <= 8) writeEnS = wePat[lat-1];
      else writeEnS = 1'b0;
      nextKey = pokeKey && (lat == 6);
      tick();
      lat++;
    end
    writeEnS  = 1'b0;
    nextKey   = 1'b0;
    expDigits = refBcd(mem[ADDR_W'(expCursor)]);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(target));
    checkOutput({tag, ".earlyValid"}, 64'(earlyValid), 64'(0));
    checkOutput({tag, ".digits"}, 64'(digits), 64'(expDigits));
    checkOutput({tag, ".valid"}, 64'(valid), 64'(1));
    checkOutput({tag, ".idle"}, 64'(busy), 64'(0));
    checkOutput({tag, ".addrAfter"}, 64'(rdAddress), 64'(expCursor));
    checkOutput({tag, ".isLatest"}, 64'(isLatest), 64'(expCursor == int'(writeAddress)));
    tick();
    checkOutput({tag, ".donePulse"}, 64'(done), 64'(0));
  endtask

  task automatic checkNoFetch(input string tag, input int addr);
    logic doneSeen;
    logic busySeen;
    doneSeen = 1'b0;
    busySeen = busy;
    repeat (DATA_W + 8) begin
      tick();
      if (done) doneSeen = 1'b1;
      if (busy) busySeen = 1'b1;
    end
    checkOutput({tag, ".done"}, 64'(doneSeen), 64'(0));
    checkOutput({tag, ".busy"}, 64'(busySeen), 64'(0));
    checkOutput({tag, ".addr"}, 64'(rdAddress), 64'(addr));
  endtask

  initial begin
    logic       dirUp;
    logic [7:0] pat;
    logic       doneSeen;
    logic       busySeen;

    reset        = 1'b0;
    viewScore    = 1'b0;
    nextKey      = 1'b0;
    prevKey      = 1'b0;
    writeEnS     = 1'b0;
    writeAddress = '0;
    for (int i = 0; i < SLOTS; i++) mem[i] = $urandom;
    mem[7]   = 32'd1234;
    mem[6]   = 32'hFFFF_FFFF;
    mem[0]   = 32'd500;
    mem[255] = 32'd1000000007;

    repeat (3) tick();
    checkOutput("reset.rdAddress", 64'(rdAddress), 64'(0));
    checkOutput("reset.digits", 64'(digits), 64'(0));
    checkOutput("reset.valid", 64'(valid), 64'(0));
    checkOutput("reset.done", 64'(done), 64'(0));
    checkOutput("reset.busy", 64'(busy), 64'(0));
    reset = 1'b1;
    tick();

    enter(7);
    runFetch("entry", 8'h00, 1'b0);
    checkOutput("entry.literal", 64'(digits), 64'h00_0000_1234);

    applyStimulus(1'b1, 1'b0);
    expCursor = stepCursor(expCursor, -1);
    checkOutput("browse.notLatest", 64'(isLatest), 64'(0));
    runFetch("browse", 8'h00, 1'b0);
    checkOutput("browse.literal", 64'(digits), 64'h42_9496_7295);

    applyStimulus(1'b0, 1'b1);
    expCursor = stepCursor(expCursor, 1);
    runFetch("contend", 8'b0000_0010, 1'b0);

    nextKey = 1'b1;
    prevKey = 1'b1;
    tick();
    nextKey = 1'b0;
    prevKey = 1'b0;
    checkNoFetch("bothKeys", expCursor);
    checkOutput("bothKeys.valid", 64'(valid), 64'(1));

    leave();
    enter(100);
    runFetch("enter100", 8'h00, 1'b1);
    for (int n = 0; n < 8; n++) begin
      dirUp = 1'($urandom_range(0, 1));
      pat   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(!dirUp, dirUp);
      expCursor = stepCursor(expCursor, dirUp ? 1 : -1);
      runFetch($sformatf("rand%0d", n), pat, 1'(n % 2));
    end

    leave();
    enter(0);
    runFetch("zero", 8'h00, 1'b0);
`ifdef SCORE_HISTORY_WRAP_EN
    applyStimulus(1'b1, 1'b0);
    expCursor = stepCursor(0, -1);
    checkOutput("wrapLow.addr", 64'(rdAddress), 64'(255));
    runFetch("wrapLow", 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1);
    expCursor = stepCursor(expCursor, 1);
    runFetch("wrapHigh", 8'h00, 1'b0);
`else
    applyStimulus(1'b1, 1'b0);
    checkNoFetch("satLow", 0);
    checkOutput("satLow.valid", 64'(valid), 64'(1));
    leave();
    enter(255);
    runFetch("top", 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkNoFetch("satHigh", 255);
    checkOutput("satHigh.valid", 64'(valid), 64'(1));
`endif

    applyStimulus(1'b1, 1'b0);
    expCursor = stepCursor(expCursor, -1);
    repeat (10) tick();
    checkOutput("abort.midBusy", 64'(busy), 64'(1));
    viewScore = 1'b0;
    tick();
    checkOutput("abort.valid", 64'(valid), 64'(0));
    checkOutput("abort.busy", 64'(busy), 64'(0));
    checkOutput("abort.digitsHeld", 64'(digits), 64'(expDigits));
    doneSeen = 1'b0;
    repeat (DATA_W + 4) begin
      tick();
      if (done) doneSeen = 1'b1;
    end
    checkOutput("abort.noDone", 64'(doneSeen), 64'(0));

    enter(42);
    repeat (12) tick();
    checkOutput("rst.midBusy", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("rst.rdAddress", 64'(rdAddress), 64'(0));
    checkOutput("rst.digits", 64'(digits), 64'(0));
    checkOutput("rst.valid", 64'(valid), 64'(0));
    checkOutput("rst.done", 64'(done), 64'(0));
    checkOutput("rst.busy", 64'(busy), 64'(0));
    tick();
    reset    = 1'b1;
    doneSeen = 1'b0;
    busySeen = 1'b0;
    repeat (DATA_W + 8) begin
      tick();
      if (done) doneSeen = 1'b1;
      if (busy) busySeen = 1'b1;
    end
    checkOutput("release.noEntryBusy", 64'(busySeen), 64'(0));
    checkOutput("release.noEntryDone", 64'(doneSeen), 64'(0));
    viewScore = 1'b0;
    tick();
    enter(42);
    runFetch("reentry", 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
